// File: rtl/mmu_pkg.sv
// MMU shared definitions: page geometry, PTE bit positions, walk states.
// Used by mmu_tlb_array and mmu_assoc.
package mmu_pkg;

  localparam int PAGE_BITS = 12;
  localparam int L1_BITS   = 10;
  localparam int L2_BITS   = 10;
  localparam int VPN_BITS  = L1_BITS + L2_BITS;
  localparam int PTE_V     = 0;
  localparam int PTE_W     = 1;

  typedef enum logic [1:0] {
    IDLE,
    PDE,
    PTE,
    FAULT
  } walk_state_t;

endpackage

// File: rtl/mmu_tlb_array.sv
// Fully-associative translation cache with round-robin victim pointer.
// Ports: lookup_vpn -> hit/hit_ppn(/hit_w); fill writes slot at victim ptr;
// inval clears all valid bits (ptr kept). MMU_WRITE_PROTECT_EN adds w bit.
module mmu_tlb_array
  import mmu_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VPN_BITS-1:0] lookup_vpn,
  input  logic                inval,
  input  logic                fill,
  input  logic [VPN_BITS-1:0] fill_vpn,
  input  logic [VPN_BITS-1:0] fill_ppn,
`ifdef MMU_WRITE_PROTECT_EN
  input  logic                fill_w,
  output logic                hit_w,
`endif
  output logic                hit,
  output logic [VPN_BITS-1:0] hit_ppn
);

  localparam int PW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [ENTRIES-1:0]  valid;
  logic [VPN_BITS-1:0] vpn_q [ENTRIES];
  logic [VPN_BITS-1:0] ppn_q [ENTRIES];
  logic [PW-1:0]       ptr;
`ifdef MMU_WRITE_PROTECT_EN
  logic [ENTRIES-1:0]  w_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      ptr   <= '0;
    end else if (inval) begin
      valid <= '0;
    end else if (fill) begin
      valid[ptr] <= 1'b1;
      ptr        <= ptr + PW'(1);
    end
  end

  // Payload needs no reset: it is only observed through valid.
  always_ff @(posedge clk) begin
    if (!rst && !inval && fill) begin
      vpn_q[ptr] <= fill_vpn;
      ppn_q[ptr] <= fill_ppn;
`ifdef MMU_WRITE_PROTECT_EN
      w_q[ptr]   <= fill_w;
`endif
    end
  end

  // Entries are only filled on a miss, so at most one can match.
  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
`ifdef MMU_WRITE_PROTECT_EN
    hit_w   = 1'b0;
`endif
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && vpn_q[i] == lookup_vpn) begin
        hit     = 1'b1;
        hit_ppn = hit_ppn | ppn_q[i];
`ifdef MMU_WRITE_PROTECT_EN
        hit_w   = hit_w | w_q[i];
`endif
      end
    end
  end

endmodule

// File: rtl/mmu_assoc.sv
// Associative MMU: translation cache, two-level walk (10/10/12), bus mux.
// Ports: clk/rst (sync, high); mmu_base_i/mmu_we/mmu_base_o base reg;
// flush_i invalidate; v_* requester side; addr_o/data_i/data_o/we_o/rd_o/
// ack_i bus side; page_fault pulse + page_fault_addr.
// Option: MMU_WRITE_PROTECT_EN faults writes to pages with w=0.
module mmu_assoc
  import mmu_pkg::*;
#(
  parameter int          ENTRIES  = 4,
  parameter logic [31:0] BASE_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mmu_base_i,
  input  logic        mmu_we,
  output logic [31:0] mmu_base_o,
  input  logic        flush_i,
  input  logic [31:0] v_addr_i,
  input  logic [31:0] v_data_i,
  output logic [31:0] v_data_o,
  input  logic        v_we_i,
  input  logic        v_rd_i,
  output logic        v_ack_o,
  output logic [31:0] addr_o,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        we_o,
  output logic        rd_o,
  input  logic        ack_i,
  output logic        page_fault,
  output logic [31:0] page_fault_addr
);

  walk_state_t         state;
  walk_state_t         state_n;
  logic [31:0]         base;
  logic [31:0]         va_q;
  logic [VPN_BITS-1:0] pde_q;
  logic                ctrl;
  logic                req;
  logic                latch;
  logic                pde_ld;
  logic                fill_en;
  logic                fault_set;
  logic [31:0]         fault_addr_n;
  logic                tlb_hit;
  logic [VPN_BITS-1:0] tlb_ppn;
  logic                wp_block;

  assign ctrl       = mmu_we | flush_i;
  assign req        = v_rd_i | v_we_i;
  assign mmu_base_o = base;
  assign v_data_o   = data_i;

`ifdef MMU_WRITE_PROTECT_EN
  logic pde_w_q;
  logic tlb_w;
  assign wp_block = v_we_i & ~tlb_w;
`else
  assign wp_block = 1'b0;
`endif

  mmu_tlb_array #(
    .ENTRIES(ENTRIES)
  ) u_tlb (
    .clk       (clk),
    .rst       (rst),
    .lookup_vpn(v_addr_i[31:PAGE_BITS]),
    .inval     (ctrl),
    .fill      (fill_en),
    .fill_vpn  (va_q[31:PAGE_BITS]),
    .fill_ppn  (data_i[31:PAGE_BITS]),
`ifdef MMU_WRITE_PROTECT_EN
    .fill_w    (pde_w_q & data_i[PTE_W]),
    .hit_w     (tlb_w),
`endif
    .hit       (tlb_hit),
    .hit_ppn   (tlb_ppn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      base            <= BASE_RST;
      va_q            <= '0;
      pde_q           <= '0;
      page_fault_addr <= '0;
`ifdef MMU_WRITE_PROTECT_EN
      pde_w_q         <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (mmu_we)    base            <= mmu_base_i;
      if (latch)     va_q            <= v_addr_i;
      if (fault_set) page_fault_addr <= fault_addr_n;
      if (pde_ld) begin
        pde_q   <= data_i[31:PAGE_BITS];
`ifdef MMU_WRITE_PROTECT_EN
        pde_w_q <= data_i[PTE_W];
`endif
      end
    end
  end

  always_comb begin
    state_n      = state;
    addr_o       = '0;
    data_o       = '0;
    we_o         = 1'b0;
    rd_o         = 1'b0;
    v_ack_o      = 1'b0;
    page_fault   = 1'b0;
    latch        = 1'b0;
    pde_ld       = 1'b0;
    fill_en      = 1'b0;
    fault_set    = 1'b0;
    fault_addr_n = va_q;
    // Base load / flush aborts everything and silences the bus.
    if (ctrl) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (tlb_hit && wp_block) begin
            state_n      = FAULT;
            fault_set    = 1'b1;
            fault_addr_n = v_addr_i;
          end else if (tlb_hit) begin
            addr_o  = {tlb_ppn, v_addr_i[PAGE_BITS-1:0]};
            data_o  = v_data_i;
            we_o    = v_we_i;
            rd_o    = v_rd_i;
            v_ack_o = ack_i;
          end else if (req) begin
            latch   = 1'b1;
            state_n = PDE;
          end
        end
        PDE: begin
          rd_o   = 1'b1;
          addr_o = base + {20'b0, va_q[31 -: L1_BITS], 2'b00};
          if (ack_i) begin
            pde_ld = 1'b1;
            if (data_i[PTE_V]) begin
              state_n = PTE;
            end else begin
              state_n   = FAULT;
              fault_set = 1'b1;
            end
          end
        end
        PTE: begin
          rd_o   = 1'b1;
          addr_o = {pde_q, va_q[PAGE_BITS +: L2_BITS], 2'b00};
          if (ack_i) begin
            if (data_i[PTE_V]) begin
              fill_en = 1'b1;
              state_n = IDLE;
            end else begin
              state_n   = FAULT;
              fault_set = 1'b1;
            end
          end
        end
        FAULT: begin
          page_fault = 1'b1;
          state_n    = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_assoc.sv
// Self-checking bench for mmu_assoc: directed table, corner sequences,
// and random accesses against a FIFO-cache page-table model.
module tb_mmu_assoc;

  localparam int NE = 4;
`ifdef MMU_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mmu_base_i;
  logic        mmu_we;
  logic [31:0] mmu_base_o;
  logic        flush_i;
  logic [31:0] v_addr_i;
  logic [31:0] v_data_i;
  logic [31:0] v_data_o;
  logic        v_we_i;
  logic        v_rd_i;
  logic        v_ack_o;
  logic [31:0] addr_o;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        we_o;
  logic        rd_o;
  logic        ack_i;
  logic        page_fault;
  logic [31:0] page_fault_addr;

  mmu_assoc #(.ENTRIES(NE), .BASE_RST(32'h0)) dut (
    .clk(clk), .rst(rst),
    .mmu_base_i(mmu_base_i), .mmu_we(mmu_we), .mmu_base_o(mmu_base_o),
    .flush_i(flush_i),
    .v_addr_i(v_addr_i), .v_data_i(v_data_i), .v_data_o(v_data_o),
    .v_we_i(v_we_i), .v_rd_i(v_rd_i), .v_ack_o(v_ack_o),
    .addr_o(addr_o), .data_i(data_i), .data_o(data_o),
    .we_o(we_o), .rd_o(rd_o), .ack_i(ack_i),
    .page_fault(page_fault), .page_fault_addr(page_fault_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  int ncmp = 0;
  int nfail = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] base_m;

  typedef struct {
    logic [19:0] vpn;
    logic [19:0] ppn;
    logic        w;
  } ent_t;
  ent_t mq[$];

  typedef struct {
    logic [31:0] va;
    logic        wr;
    logic        flt;
    int          nack;
    logic [31:0] phys;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_base(input logic [31:0] b);
    mmu_we = 1'b1;
    mmu_base_i = b;
    @(negedge clk);
    mmu_we = 1'b0;
    base_m = b;
    mq.delete();
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    mq.delete();
  endtask

  // Drives one request and plays the bus; starts and ends on a negedge.
  task automatic access(input logic [31:0] va, input logic wr,
                        output int nack, output logic flt,
                        output logic [31:0] phys, output logic [31:0] a0,
                        output logic [31:0] a1, output int viol);
    int dly;
    bit done;
    nack = 0; flt = 1'b0; phys = '0; a0 = '0; a1 = '0; viol = 0;
    done = 1'b0;
    v_addr_i = va; v_we_i = wr; v_rd_i = !wr; v_data_i = ~va;
    dly = $urandom_range(0, 2);
    for (int c = 0; c < 80 && !done; c++) begin
      ack_i = 1'b0; data_i = '0;
      #1;
      if (v_ack_o) viol++;
      if (page_fault) begin
        flt = 1'b1;
        done = 1'b1;
      end else if (rd_o || we_o) begin
        if (dly == 0) begin
          ack_i = 1'b1;
          data_i = we_o ? 32'h0 : rd(addr_o);
          if (nack == 0) a0 = addr_o;
          else if (nack == 1) a1 = addr_o;
          nack++;
          #1;
          if (v_ack_o) begin
            phys = addr_o;
            done = 1'b1;
            if (wr && data_o !== ~va) viol++;
            if (!wr && v_data_o !== data_i) viol++;
          end else if (we_o || data_o != 32'h0) begin
            viol++;
          end
          dly = $urandom_range(0, 2);
        end else begin
          dly--;
        end
      end
      @(negedge clk);
    end
    if (!done) viol += 1000;
    v_rd_i = 1'b0; v_we_i = 1'b0; ack_i = 1'b0; data_i = '0;
    #1;
    if (page_fault || rd_o || we_o || v_ack_o) viol++;
    @(negedge clk);
  endtask

  task automatic run(input string nm, input logic [31:0] va,
                     input logic wr, input logic ef, input int en,
                     input logic [31:0] ep);
    int n, viol;
    logic f;
    logic [31:0] p, a0, a1;
    access(va, wr, n, f, p, a0, a1, viol);
    chk({nm, ".fault"}, 32'(f), 32'(ef));
    chk({nm, ".acks"}, n, en);
    if (ef) chk({nm, ".pf_addr"}, page_fault_addr, va);
    else chk({nm, ".phys"}, p, ep);
    chk({nm, ".proto"}, viol, 0);
  endtask

  // Reference: walk the page tables in memory directly.
  task automatic walk(input logic [31:0] va, output logic ok,
                      output int n, output logic [19:0] ppn,
                      output logic w);
    logic [31:0] pde, pte;
    pde = rd(base_m + 32'(va[31:22]) * 4);
    ok = 1'b0; n = 1; ppn = '0; w = 1'b0;
    if (pde[0]) begin
      pte = rd({pde[31:12], 12'h0} + 32'(va[21:12]) * 4);
      n = 2;
      if (pte[0]) begin
        ok = 1'b1;
        ppn = pte[31:12];
        w = pde[1] & pte[1];
      end
    end
  endtask

  // Reference: FIFO cache of translations, evicting the oldest fill.
  task automatic predict(input logic [31:0] va, input logic wr,
                         output logic ef, output int en,
                         output logic [31:0] ep);
    int idx;
    logic ok, w;
    int n;
    logic [19:0] ppn;
    idx = -1;
    foreach (mq[i]) if (mq[i].vpn == va[31:12]) idx = i;
    ef = 1'b0; en = 0; ep = '0;
    if (idx >= 0) begin
      if (WP && wr && !mq[idx].w) ef = 1'b1;
      else begin en = 1; ep = {mq[idx].ppn, va[11:0]}; end
    end else begin
      walk(va, ok, n, ppn, w);
      if (!ok) begin
        ef = 1'b1; en = n;
      end else begin
        mq.push_back('{vpn: va[31:12], ppn: ppn, w: w});
        if (mq.size() > NE) void'(mq.pop_front());
        if (WP && wr && !w) begin ef = 1'b1; en = 2; end
        else begin en = 3; ep = {ppn, va[11:0]}; end
      end
    end
  endtask

  initial begin
    int n, viol;
    logic f;
    logic [31:0] p, a0, a1;
    logic [31:0] va;
    logic ef;
    int en;
    logic [31:0] ep;

    rst = 1'b1; mmu_we = 1'b0; mmu_base_i = '0; flush_i = 1'b0;
    v_addr_i = '0; v_data_i = '0; v_we_i = 1'b0; v_rd_i = 1'b0;
    data_i = '0; ack_i = 1'b0; base_m = '0;

    for (int i = 1; i <= 4; i++)
      mem[32'h2000 + 32'(i) * 4] = ((32'h10 + 32'(i)) << 12) | 32'h3;
    mem[32'h2014] = 32'h0000_7003;
    mem[32'h2018] = 32'h0000_7001;
    mem[32'h201C] = 32'h0;
    mem[32'h1000] = 32'h0;

    tbl[0]  = '{32'h0000_1004, 1'b0, 1'b0, 3, 32'h0001_1004};
    tbl[1]  = '{32'h0000_2008, 1'b0, 1'b0, 3, 32'h0001_2008};
    tbl[2]  = '{32'h0000_3000, 1'b0, 1'b0, 3, 32'h0001_3000};
    tbl[3]  = '{32'h0000_4FFC, 1'b0, 1'b0, 3, 32'h0001_4FFC};
    tbl[4]  = '{32'h0000_5ABC, 1'b0, 1'b0, 3, 32'h0000_7ABC};
    tbl[5]  = '{32'h0000_2010, 1'b0, 1'b0, 1, 32'h0001_2010};
    tbl[6]  = '{32'h0000_3124, 1'b1, 1'b0, 1, 32'h0001_3124};
    tbl[7]  = '{32'h0000_4000, 1'b0, 1'b0, 1, 32'h0001_4000};
    tbl[8]  = '{32'h0000_5000, 1'b0, 1'b0, 1, 32'h0000_7000};
    tbl[9]  = '{32'h0000_1FF0, 1'b0, 1'b0, 3, 32'h0001_1FF0};
    tbl[10] = '{32'h0000_2000, 1'b0, 1'b0, 3, 32'h0001_2000};
    tbl[11] = '{32'h0000_7000, 1'b0, 1'b1, 2, 32'h0};
    tbl[12] = '{32'h0040_0000, 1'b0, 1'b1, 1, 32'h0};
    tbl[13] = '{32'h0000_5004, 1'b0, 1'b0, 1, 32'h0000_7004};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.base", mmu_base_o, 32'h0);
    chk("rst.pf", 32'(page_fault), 32'h0);
    chk("rst.pf_addr", page_fault_addr, 32'h0);
    chk("rst.strobes", {30'h0, rd_o, we_o}, 32'h0);
    chk("rst.vack", 32'(v_ack_o), 32'h0);
    @(negedge clk);

    set_base(32'h1000);
    chk("base.load", mmu_base_o, 32'h1000);

    // PDE invalid: single fault pulse, no fill.
    run("t2", 32'h0000_5000, 1'b0, 1'b1, 1, 32'h0);
    mem[32'h1000] = 32'h0000_2003;

    // First translation: PDE read, PTE read, then mapped access.
    access(32'h0000_5ABC, 1'b0, n, f, p, a0, a1, viol);
    chk("t1.pde_addr", a0, 32'h1000);
    chk("t1.pte_addr", a1, 32'h2014);
    chk("t1.phys", p, 32'h0000_7ABC);
    chk("t1.acks", n, 3);
    chk("t1.proto", viol, 0);

    // Flush: base kept, page re-walks.
    do_flush();
    chk("t6.base", mmu_base_o, 32'h1000);
    run("t6.rewalk", 32'h0000_5ABC, 1'b0, 1'b0, 3, 32'h0000_7ABC);
    do_flush();

    foreach (tbl[i])
      run($sformatf("tbl%0d", i), tbl[i].va, tbl[i].wr, tbl[i].flt,
          tbl[i].nack, tbl[i].phys);

    // mmu_we coinciding with the PTE ack: no fill, all invalid.
    do_flush();
    run("t4.pre", 32'h0000_3000, 1'b0, 1'b0, 3, 32'h0001_3000);
    v_addr_i = 32'h0000_2000; v_rd_i = 1'b1; ack_i = 1'b0;
    @(negedge clk);
    #1;
    chk("t4.pde_rd", {rd_o, addr_o[30:0]}, {1'b1, 31'h1000});
    ack_i = 1'b1; data_i = rd(32'h1000);
    @(negedge clk);
    ack_i = 1'b0; data_i = '0;
    #1;
    chk("t4.pte_addr", addr_o, 32'h2008);
    ack_i = 1'b1; data_i = rd(32'h2008);
    mmu_we = 1'b1; mmu_base_i = 32'h3000;
    #1;
    chk("t4.quiet", {29'h0, rd_o, we_o, v_ack_o}, 32'h0);
    @(negedge clk);
    mmu_we = 1'b0; v_rd_i = 1'b0; ack_i = 1'b0; data_i = '0;
    #1;
    chk("t4.base", mmu_base_o, 32'h3000);
    chk("t4.idle", 32'(rd_o), 32'h0);
    @(negedge clk);
    set_base(32'h1000);
    run("t4.inval", 32'h0000_3000, 1'b0, 1'b0, 3, 32'h0001_3000);
    run("t4.nofill", 32'h0000_2000, 1'b0, 1'b0, 3, 32'h0001_2000);
    run("t4.hit", 32'h0000_2004, 1'b0, 1'b0, 1, 32'h0001_2004);

    // Read-only page write.
    do_flush();
    if (WP) begin
      run("t5.walk_wr", 32'h0000_6010, 1'b1, 1'b1, 2, 32'h0);
      run("t5.hit_wr", 32'h0000_6014, 1'b1, 1'b1, 0, 32'h0);
    end else begin
      run("t5.walk_wr", 32'h0000_6010, 1'b1, 1'b0, 3, 32'h0000_7010);
      run("t5.hit_wr", 32'h0000_6014, 1'b1, 1'b0, 1, 32'h0000_7014);
    end
    run("t5.hit_rd", 32'h0000_6020, 1'b0, 1'b0, 1, 32'h0000_7020);

    // Random accesses against the model.
    do_flush();
    for (int k = 0; k < 200; k++) begin
      int s;
      logic wr;
      s = $urandom_range(0, 8);
      va[31:12] = (s < 8) ? 20'(s + 1) : 20'h00400;
      va[11:0] = 12'($urandom);
      wr = ($urandom_range(0, 2) == 0);
      predict(va, wr, ef, en, ep);
      run($sformatf("rnd%0d", k), va, wr, ef, en, ep);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
